ibex_md_issue_ctrl: RTL and testbench

Requester-side controller for `ibex_multdiv_fast`. It accepts one M-extension operation at a time over a valid/ready request channel and drives the multdiv enable, select, operator and operand inputs, holding them stable until the unit completes. It owns the two `imd_val` intermediate registers and returns the 32-bit result over a valid/ready response channel. It sits between the ID-stage issue logic, or a stimulus sequencer in benches, and the multdiv unit.

---
 rtl/ibex_md_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_ibex_md_issue_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_md_issue_ctrl.sv
// rtl/ibex_md_issue_ctrl.sv - requester-side issue controller for ibex_multdiv_fast
module ibex_md_issue_ctrl #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [1:0]       req_signed_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_timeout_o,
    output logic [15:0]      rsp_cycles_o,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             mult_sel_o,
    output logic             div_sel_o,
    output logic [1:0]       operator_o,
    output logic [1:0]       signed_mode_o,
    output logic [31:0]      op_a_o,
    output logic [31:0]      op_b_o,
    output logic             multdiv_ready_id_o,
    output logic [1:0][33:0] imd_val_q_o,
    input  logic [1:0][33:0] imd_val_d_i,
    input  logic [1:0]       imd_val_we_i,
    input  logic             md_valid_i,
    input  logic [31:0]      md_result_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [15:0] TimeoutLim = 16'(TimeoutCycles);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       sgn_q, sgn_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      cnt_inc;
    logic [31:0]      data_q, data_d;
    logic             to_q, to_d;
    logic [15:0]      cyc_q, cyc_d;
    logic [1:0][33:0] imd_q;
    logic             busy;
    logic             is_div;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        to_d    = to_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    sgn_d   = req_signed_i;
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    cnt_d   = 16'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                // A result arriving on the timeout cycle still counts as a result.
                if (md_valid_i) begin
                    data_d  = md_result_i;
                    to_d    = 1'b0;
                    cyc_d   = cnt_inc;
                    state_d = RESP;
                end else if (cnt_inc >= TimeoutLim) begin
                    data_d  = 32'd0;
                    to_d    = 1'b1;
                    cyc_d   = TimeoutLim;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            sgn_q   <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            cnt_q   <= 16'd0;
            data_q  <= 32'd0;
            to_q    <= 1'b0;
            cyc_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            to_q    <= to_d;
            cyc_q   <= cyc_d;
        end
    end

    // The multdiv unit owns the write enables; halves update independently of the FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            imd_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (imd_val_we_i[i]) begin
                    imd_q[i] <= imd_val_d_i[i];
                end
            end
        end
    end

    assign busy   = (state_q == BUSY);
    assign is_div = op_q[1];

    assign req_ready_o        = (state_q == IDLE);
    assign rsp_valid_o        = (state_q == RESP);
    assign rsp_data_o         = data_q;
    assign rsp_timeout_o      = to_q;
    assign rsp_cycles_o       = cyc_q;
    assign mult_en_o          = busy & ~is_div;
    assign mult_sel_o         = busy & ~is_div;
    assign div_en_o           = busy & is_div;
    assign div_sel_o          = busy & is_div;
    assign multdiv_ready_id_o = busy;
    assign operator_o         = op_q;
    assign signed_mode_o      = sgn_q;
    assign op_a_o             = a_q;
    assign op_b_o             = b_q;
    assign imd_val_q_o        = imd_q;

endmodule

// File: tb/tb_ibex_md_issue_ctrl.sv
// tb/tb_ibex_md_issue_ctrl.sv - randomized self-checking bench for ibex_md_issue_ctrl
module tb_ibex_md_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             use_t = 1'b0;
    logic             req_valid = 1'b0;
    logic             rsp_ready = 1'b0;
    logic             md_valid = 1'b0;
    logic [1:0]       req_op = 2'd0;
    logic [1:0]       req_sg = 2'd0;
    logic [31:0]      req_a = 32'd0;
    logic [31:0]      req_b = 32'd0;
    logic [31:0]      md_result = 32'd0;
    logic [1:0][33:0] imd_d = '0;
    logic [1:0]       imd_we = 2'd0;
    logic [1:0][33:0] imd_m = '0;

    logic             m_req_ready, t_req_ready, m_rsp_valid, t_rsp_valid;
    logic [31:0]      m_rsp_data, t_rsp_data;
    logic             m_rsp_to, t_rsp_to;
    logic [15:0]      m_rsp_cyc, t_rsp_cyc;
    logic             m_men, t_men, m_den, t_den, m_msel, t_msel, m_dsel, t_dsel;
    logic [1:0]       m_opr, t_opr, m_sgn, t_sgn;
    logic [31:0]      m_a, t_a, m_b, t_b;
    logic             m_rid, t_rid;
    logic [1:0][33:0] m_imd, t_imd;

    ibex_md_issue_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid & ~use_t), .req_ready_o(m_req_ready),
        .req_op_i(req_op), .req_signed_i(req_sg), .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(m_rsp_valid), .rsp_ready_i(rsp_ready & ~use_t),
        .rsp_data_o(m_rsp_data), .rsp_timeout_o(m_rsp_to), .rsp_cycles_o(m_rsp_cyc),
        .mult_en_o(m_men), .div_en_o(m_den), .mult_sel_o(m_msel), .div_sel_o(m_dsel),
        .operator_o(m_opr), .signed_mode_o(m_sgn), .op_a_o(m_a), .op_b_o(m_b),
        .multdiv_ready_id_o(m_rid), .imd_val_q_o(m_imd), .imd_val_d_i(imd_d),
        .imd_val_we_i(imd_we), .md_valid_i(md_valid & ~use_t), .md_result_i(md_result)
    );

    ibex_md_issue_ctrl #(.TimeoutCycles(8)) dut_to (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid & use_t), .req_ready_o(t_req_ready),
        .req_op_i(req_op), .req_signed_i(req_sg), .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(t_rsp_valid), .rsp_ready_i(rsp_ready & use_t),
        .rsp_data_o(t_rsp_data), .rsp_timeout_o(t_rsp_to), .rsp_cycles_o(t_rsp_cyc),
        .mult_en_o(t_men), .div_en_o(t_den), .mult_sel_o(t_msel), .div_sel_o(t_dsel),
        .operator_o(t_opr), .signed_mode_o(t_sgn), .op_a_o(t_a), .op_b_o(t_b),
        .multdiv_ready_id_o(t_rid), .imd_val_q_o(t_imd), .imd_val_d_i(imd_d),
        .imd_val_we_i(imd_we), .md_valid_i(md_valid & use_t), .md_result_i(md_result)
    );

    logic        o_req_ready, o_rsp_valid, o_rsp_to, o_rid;
    logic [31:0] o_rsp_data, o_a, o_b;
    logic [15:0] o_rsp_cyc;
    logic [1:0]  o_mult, o_div, o_opr, o_sgn;
    assign o_req_ready = use_t ? t_req_ready : m_req_ready;
    assign o_rsp_valid = use_t ? t_rsp_valid : m_rsp_valid;
    assign o_rsp_data  = use_t ? t_rsp_data  : m_rsp_data;
    assign o_rsp_to    = use_t ? t_rsp_to    : m_rsp_to;
    assign o_rsp_cyc   = use_t ? t_rsp_cyc   : m_rsp_cyc;
    assign o_mult      = use_t ? {t_men, t_msel} : {m_men, m_msel};
    assign o_div       = use_t ? {t_den, t_dsel} : {m_den, m_dsel};
    assign o_opr       = use_t ? t_opr : m_opr;
    assign o_sgn       = use_t ? t_sgn : m_sgn;
    assign o_a         = use_t ? t_a : m_a;
    assign o_b         = use_t ? t_b : m_b;
    assign o_rid       = use_t ? t_rid : m_rid;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (imd_we[i] && !rst) imd_m[i] = imd_d[i];
        imd_we = 2'd0;
    endtask

    // Architectural M-extension result, used as the multdiv unit's answer.
    function automatic logic [31:0] md_model(input logic [1:0] op, input logic [1:0] sg,
                                             input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = sg[0] ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg[1] ? longint'($signed(b)) : longint'({32'd0, b});
        p  = sa * sb;
        if (b == 32'd0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return q[31:0];
            default: return r[31:0];
        endcase
    endfunction

    task automatic check_resp(input logic [31:0] d, input bit to, input int cyc,
                              input logic [1:0] op, input logic [1:0] sg);
        check("rsp_valid", o_rsp_valid, 1);
        check("rsp_data", o_rsp_data, d);
        check("rsp_timeout", o_rsp_to, to);
        check("rsp_cycles", o_rsp_cyc, cyc);
        check("resp_ctrl", {o_mult, o_div, o_rid, o_req_ready}, 0);
        check("resp_hold_op", {o_opr, o_sgn}, {op, sg});
    endtask

    task automatic run_op(input bit t, input logic [1:0] op, input logic [1:0] sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int bp, input bit imd_dir);
        int          tmo, n, exp_cyc;
        bit          exp_to, done;
        logic [31:0] res, exp_data;
        use_t = t;
        tmo   = t ? 8 : 64;
        res   = md_model(op, sg, a, b);
        exp_to   = (lat > tmo);
        exp_cyc  = exp_to ? tmo : lat;
        exp_data = exp_to ? 32'd0 : res;
        req_op = op; req_sg = sg; req_a = a; req_b = b; req_valid = 1'b1;
        #1;
        check("idle_req_ready", o_req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_op = 2'($urandom); req_sg = 2'($urandom); req_a = $urandom; req_b = $urandom;
        n = 0;
        done = 0;
        while (!done) begin
            n++;
            check("busy_mult", o_mult, (op < 2) ? 2'b11 : 2'b00);
            check("busy_div", o_div, (op >= 2) ? 2'b11 : 2'b00);
            check("busy_opr_sgn", {o_opr, o_sgn}, {op, sg});
            check("busy_operands", {o_a, o_b}, {a, b});
            check("busy_flags", {o_rid, o_req_ready, o_rsp_valid}, 3'b100);
            if (imd_dir && n == 1) begin
                imd_we = 2'b01;
                imd_d[0] = 34'h1;
                imd_d[1] = {2'($urandom), $urandom};
            end else begin
                imd_we = 2'($urandom);
                imd_d[0] = {2'($urandom), $urandom};
                imd_d[1] = {2'($urandom), $urandom};
            end
            md_valid  = (n == lat);
            md_result = (n == lat) ? res : $urandom;
            tick();
            md_valid = 1'b0;
            check("imd0", m_imd[0], imd_m[0]);
            check("imd1", m_imd[1], imd_m[1]);
            if (n == lat || n >= tmo) done = 1;
        end
        check_resp(exp_data, exp_to, exp_cyc, op, sg);
        for (int i = 0; i < bp; i++) begin
            md_valid  = 1'($urandom);
            md_result = $urandom;
            tick();
            md_valid = 1'b0;
            check_resp(exp_data, exp_to, exp_cyc, op, sg);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("back_idle", {o_req_ready, o_rsp_valid, o_mult, o_div, o_rid}, 7'b1000000);
        use_t = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        check("rst_ctrl", {m_men, m_msel, m_den, m_dsel, m_rid}, 0);
        check("rst_req_ready", m_req_ready, 1);
        check("rst_rsp", {m_rsp_valid, m_rsp_to, m_rsp_cyc, m_rsp_data}, 0);
        check("rst_hold", {m_opr, m_sgn, m_a, m_b}, 0);
        check("rst_imd", m_imd, 0);
        rst = 1'b0;
        tick();

        run_op(0, 2'd0, 2'b00, 32'd7, 32'd6, 1, 0, 0);
        run_op(0, 2'd2, 2'b00, 32'd100, 32'd7, 34, 0, 0);
        run_op(0, 2'd1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 0, 1);
        run_op(0, 2'd3, 2'b01, $urandom, $urandom, 5, 5, 0);
        run_op(1, 2'd0, 2'b00, 32'd5, 32'd5, 1000, 3, 0);
        run_op(1, 2'd2, 2'b11, $urandom, $urandom, 8, 1, 0);

        req_op = 2'd3; req_sg = 2'b11; req_a = 32'd55; req_b = 32'd6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        check("rem_busy_div", {m_den, m_dsel}, 2'b11);
        rst = 1'b1;
        #1;
        imd_m = '0;
        check("abort_ctrl", {m_men, m_msel, m_den, m_dsel, m_rid}, 0);
        check("abort_ready", {m_req_ready, m_rsp_valid}, 2'b10);
        check("abort_hold", {m_opr, m_rsp_cyc}, 0);
        check("abort_imd", m_imd, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_rsp", {m_rsp_valid, m_req_ready}, 2'b01);
        end
        run_op(0, 2'd0, 2'b00, 32'd3, 32'd3, 1, 0, 0);

        for (int k = 0; k < 24; k++) begin
            bit t;
            t = 1'($urandom);
            run_op(t, 2'($urandom), 2'($urandom), $urandom, $urandom,
                   t ? $urandom_range(1, 12) : $urandom_range(1, 40),
                   $urandom_range(0, 3), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
